// File: rtl/ilv_pkg.sv
// Shared definitions for the block interleaver: mode encoding and the
// read-address permutation used during bank read-out.
package ilv_pkg;

  typedef enum logic {
    ILV_MODE_INTLV   = 1'b0,
    ILV_MODE_DEINTLV = 1'b1
  } ilv_mode_e;

  // Interleave reads a ROWS x COLS row-major bank column by column;
  // deinterleave applies the transposed walk so the two modes cancel.
  function automatic int unsigned ilv_raddr(input int unsigned k,
                                            input int unsigned rows,
                                            input int unsigned cols,
                                            input ilv_mode_e   mode);
    int unsigned addr;
    if (mode == ILV_MODE_DEINTLV) addr = (k % cols) * rows + k / cols;
    else                          addr = (k % rows) * cols + k / rows;
    return addr;
  endfunction

endpackage

// File: rtl/ilv_bank_ram.sv
// One N x W storage bank: a single write port plus a registered read port
// whose output register holds its value until the next read.
module ilv_bank_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 1,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register is reset so the top-level data output starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_block_interleaver.sv
// Ping-pong block interleaver: one bank fills linearly while the other,
// already full, is read out in permuted order in lock-step with the input.
module param_block_interleaver
  import ilv_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned W    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         mode_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         sof_o
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = $clog2(N);

  logic [AW-1:0] k;
  logic [AW-1:0] raddr;
  logic          wsel;
  logic          rsel;
  logic          out_sel;
  logic [1:0]    full;
  logic [1:0]    we;
  logic [1:0]    re;
  ilv_mode_e     bank_mode [2];
  logic [W-1:0]  rdata [2];

  assign rsel  = ~wsel;
  assign raddr = AW'(ilv_raddr(32'(k), ROWS, COLS, bank_mode[rsel]));

  always_comb begin
    we       = '0;
    re       = '0;
    we[wsel] = valid_i;
    re[rsel] = valid_i & full[rsel];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ilv_bank_ram #(
      .DEPTH (N),
      .W     (W),
      .AW    (AW)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we[b]),
      .waddr (k),
      .wdata (data_i),
      .re    (re[b]),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  // out_sel remembers which bank produced the last read so data_o holds.
  assign data_o = rdata[out_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k            <= '0;
      wsel         <= 1'b0;
      out_sel      <= 1'b0;
      full         <= '0;
      bank_mode[0] <= ILV_MODE_INTLV;
      bank_mode[1] <= ILV_MODE_INTLV;
      valid_o      <= 1'b0;
      sof_o        <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      if (valid_i) begin
        if (k == '0) bank_mode[wsel] <= ilv_mode_e'(mode_i);
        if (full[rsel]) begin
          valid_o <= 1'b1;
          sof_o   <= (k == '0);
          out_sel <= rsel;
        end
        // Last symbol of a block: hand the filled bank over to the reader.
        if (k == AW'(N - 1)) begin
          k          <= '0;
          wsel       <= ~wsel;
          full[wsel] <= 1'b1;
          full[rsel] <= 1'b0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule
